// File: rtl/johnson_pkg.sv
// Shared helpers for Johnson (twisted-ring) counters: phase<->code mapping and validity.
// Codes are carried LSB-aligned in a JOHNSON_MAX_W-bit container; callers pass the real width.
// Phase k < W: top k+1 bits set. Phase k >= W: top k-W+1 bits clear, rest set.
package johnson_pkg;

  localparam int JOHNSON_MAX_W = 32;

  typedef logic [JOHNSON_MAX_W-1:0] jcode_t;

  // Per-edge operation chosen by the counter core.
  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_STEP_UP = 3'd1,
    OP_STEP_DN = 3'd2,
    OP_LOAD    = 3'd3,
    OP_CORRECT = 3'd4
  } jop_e;

  // Johnson code of a phase index; an out-of-range index maps to phase 0.
  function automatic jcode_t phase_to_code(input int width, input int phase);
    jcode_t code;
    int     p;
    int     t;
    code = '0;
    p    = (phase >= 0 && phase < 2 * width) ? phase : 0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      t = width - 1 - i;
      if (i < width) begin
        if (p < width) code[i] = (t <= p);
        else           code[i] = (t >= p - width + 1);
      end
    end
    return code;
  endfunction

  // A code is valid when at most one adjacent-bit transition exists.
  function automatic bit code_is_valid(input int width, input jcode_t code);
    int trans;
    trans = 0;
    for (int i = 0; i < JOHNSON_MAX_W - 1; i++) begin
      if (i < width - 1 && code[i] != code[i+1]) trans++;
    end
    return (trans <= 1);
  endfunction

  // Binary phase of a code; illegal codes decode to 0.
  function automatic int code_to_phase(input int width, input jcode_t code);
    int ones;
    ones = 0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i < width && code[i]) ones++;
    end
    if (!code_is_valid(width, code)) return 0;
    if (code[width-1]) return ones - 1;
    return width + (width - ones) - 1;
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational Johnson code -> binary phase decoder with illegal-code flag.
// Latency: zero (pure combinational). Reusable by monitors outside the counter.
// No backpressure; outputs follow the input code continuously.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   i_count,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_illegal
);

  if (WIDTH < 2 || WIDTH > JOHNSON_MAX_W) begin : g_bad_width
    $error("johnson_phase_decode: WIDTH out of supported range");
  end

  jcode_t w_code_ext;

  assign w_code_ext = jcode_t'(i_count);

  // Decode phase and flag codes with more than one adjacent-bit transition.
  always_comb begin
    o_illegal = !code_is_valid(WIDTH, w_code_ext);
    o_phase   = PHASE_W'(code_to_phase(WIDTH, w_code_ext));
  end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised up/down Johnson counter with phase load, phase decode, wrap strobe, illegal flag.
// Latency: one falling edge for step/load; Phase_Out/Illegal_Out combinational from Count_Out.
// No backpressure; Load_In > Enable_In > hold. Optional JOHNSON_SELF_CORRECT_EN forces phase 0 on illegal codes.
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic               Clk_In,
  input  logic               Reset_In,
  input  logic               Enable_In,
  input  logic               Dir_In,
  input  logic               Load_In,
  input  logic [PHASE_W-1:0] Load_Phase_In,
  output logic [WIDTH-1:0]   Count_Out,
  output logic [PHASE_W-1:0] Phase_Out,
  output logic               Wrap_Out,
  output logic               Illegal_Out
);

  localparam logic [WIDTH-1:0] PHASE0_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic             w_illegal;
  logic             w_correct;
  jop_e             w_op;
  logic [WIDTH-1:0] w_load_code;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;

  johnson_phase_decode #(
    .WIDTH(WIDTH)
  ) u_decode (
    .i_count  (r_count),
    .o_phase  (Phase_Out),
    .o_illegal(w_illegal)
  );

`ifdef JOHNSON_SELF_CORRECT_EN
  assign w_correct = w_illegal;
`else
  assign w_correct = 1'b0;
`endif

  // The load path always goes through the phase map, so it cannot produce an illegal code.
  assign w_load_code = WIDTH'(phase_to_code(WIDTH, int'(Load_Phase_In)));

  // Pick this edge's operation: correction > load > enabled step > hold.
  always_comb begin
    w_op = OP_HOLD;
    if (w_correct)      w_op = OP_CORRECT;
    else if (Load_In)   w_op = OP_LOAD;
    else if (Enable_In) w_op = Dir_In ? OP_STEP_UP : OP_STEP_DN;
  end

  // Next code and wrap strobe; wrap only on an enabled step across the 2W-1/0 boundary.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    case (w_op)
      OP_CORRECT: w_next_count = PHASE0_CODE;
      OP_LOAD:    w_next_count = w_load_code;
      OP_STEP_UP: begin
        w_next_count = {~r_count[0], r_count[WIDTH-1:1]};
        w_next_wrap  = (r_count == '0);
      end
      OP_STEP_DN: begin
        w_next_count = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
        w_next_wrap  = (r_count == PHASE0_CODE);
      end
      default: ;
    endcase
  end

  // State register: falling-edge update, asynchronous active-high reset to phase 0.
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_count <= PHASE0_CODE;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
    end
  end

  assign Count_Out   = r_count;
  assign Wrap_Out    = r_wrap;
  assign Illegal_Out = w_illegal;

endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
Parametrised Johnson (twisted-ring) counter; next generation of the team's fixed 8-bit Johnson counter.
- Adds: generic width, up/down direction, synchronous phase load, binary phase decode, wrap pulse and illegal-code detection.
- Sits in the counters/timers library as a glitch-free multi-phase sequencer and timing-strobe source for sequencing logic.

Parameters:
WIDTH, 8, number of counter flops; sequence length is 2*WIDTH; minimum 2.
PHASE_W, $clog2(2*WIDTH), width of phase index ports (derived localparam, not overridable).

Ports:
Clk_In  input  1  clock; all state updates on falling edge.
Reset_In  input  1  reset; asynchronous, active-high.
Enable_In  input  1  1 = advance one phase per clock; 0 = hold.
Dir_In  input  1  1 = up (shift right, MSB <= ~LSB); 0 = down (shift left, LSB <= ~MSB).
Load_In  input  1  synchronous load of phase Load_Phase_In.
Load_Phase_In  input  PHASE_W  phase index to load, 0..2*WIDTH-1.
Count_Out  output  WIDTH  registered Johnson code.
Phase_Out  output  PHASE_W  combinational binary phase of Count_Out.
Wrap_Out  output  1  registered one-cycle wrap strobe.
Illegal_Out  output  1  combinational; Count_Out is not a valid Johnson code.

Behaviour:
- Reset (async): Count_Out = {1'b1, {WIDTH-1{1'b0}}} (phase 0); Wrap_Out = 0. Reset mid-count aborts immediately; no partial state retained.
- Phase map, k in 0..WIDTH-1: top k+1 bits 1, rest 0.
- Phase map, k in WIDTH..2*WIDTH-1: top k-WIDTH+1 bits 0, rest 1.
- WIDTH=8 examples: 1000_0000=0, 1111_1111=7, 0111_1111=8, 0000_0000=15.
- Priority per falling edge: Load_In > Enable_In > hold. Dir_In is ignored during load and hold.
- Load: Count_Out <= code(Load_Phase_In). Load_Phase_In >= 2*WIDTH (non-power-of-2 WIDTH only) loads phase 0. Latency 1 edge.
- Enable, up: phase k -> (k+1) mod 2W. Enable, down: phase k -> (k-1) mod 2W. Direction change takes effect at the next edge with no dead cycle.
- Wrap_Out: 1 for exactly the cycle following an enabled step that moves 2W-1 -> 0 (up) or 0 -> 2W-1 (down). It is 0 after loads, even a load of phase 0, and 0 on hold.
- Valid code: at most one bit transition between adjacent bits of Count_Out.
- Phase decode: MSB=1 -> Phase_Out = popcount-1. MSB=0 -> Phase_Out = WIDTH + zerocount - 1.
- Illegal code: Illegal_Out=1, Phase_Out=0.
- Illegal codes are reachable only by upset or force; the load path never produces one.

Optional Feature:
Macro JOHNSON_SELF_CORRECT_EN.
- Defined: at any falling edge where the current code is illegal, Count_Out <= phase 0 code. This overrides Load/Enable/hold; Wrap_Out = 0 that cycle. Illegal_Out is visible for the one cycle before correction.
- Undefined: illegal codes shift/hold per normal rules, may persist indefinitely, and Illegal_Out tracks them.

Decomposition:
- Shared package johnson_pkg: function for phase-to-code, function for code validity, function for code-to-phase. Each takes WIDTH as an argument or is parameterised by it.
- One natural sub-module: johnson_phase_decode. Purely combinational; maps Count_Out to Phase_Out and Illegal_Out; reusable by monitors.
- Counter core stays in the top module.

Test Plan:
1. WIDTH=8, reset, Enable=1, Dir=1 for 17 edges. Count_Out steps 80,C0,...,FF,7F,...,01,00,80. Phase_Out 0..15,0. Wrap_Out=1 only in the cycle after 00->80.
2. Dir=0 from reset. Count_Out 80->00->01->03, Phase_Out 0->15->14->13. Wrap_Out pulses once after 80->00.
3. Load_In=1, Load_Phase_In=9 with Enable=1. Count_Out=3F, no Wrap_Out. Next enabled up step gives 1F (phase 10).
4. Enable=0 for 5 edges at phase 7. Count_Out stays FF, Wrap_Out 0. Async Reset_In pulse mid-cycle sets Count_Out=80 immediately, without waiting for a clock edge.
5. Force Count_Out=8'hA5. Illegal_Out=1, Phase_Out=0. With JOHNSON_SELF_CORRECT_EN, next edge gives 80. Without it, Illegal_Out stays 1 after the shift.
6. WIDTH=5, Load_Phase_In=12 (out of range) loads 10000 (phase 0). Full up sequence has 10 states; Wrap_Out period is 10 cycles.
